// File: rtl/stream_fifo.sv
// stream_fifo: DEPTH-entry circular FIFO for a valid/ready stream with first/last sidebands.
// Optional input-side framing checker (frame_err port) under STREAM_FIFO_FRAME_CHECK_EN.
module stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_rx,
   output logic                     ready_rx,
   input  logic                     first_rx,
   input  logic                     last_rx,
   input  logic [WIDTH-1:0]         payload_rx,
   output logic                     valid_tx,
   input  logic                     ready_tx,
   output logic                     first_tx,
   output logic                     last_tx,
   output logic [WIDTH-1:0]         payload_tx,
`ifdef STREAM_FIFO_FRAME_CHECK_EN
   output logic                     frame_err,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0] ZERO_C  = {PW{1'b0}};
   localparam logic [PW-1:0] ONE_C   = PW'(1);

   logic [WIDTH+1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PW-1:0]    count_r;
   logic [PW-1:0]    count_next_s;
   logic             active_r;
   logic             push_s;
   logic             pop_s;
   logic [WIDTH+1:0] head_s;

   assign ready_rx = (count_r != DEPTH_C) & active_r;
   assign valid_tx = (count_r != ZERO_C);
   assign push_s   = valid_rx & ready_rx;
   assign pop_s    = valid_tx & ready_tx;
   assign head_s   = mem_r[rd_ptr_r[AW-1:0]];
   assign count    = count_r;

   // Holds ready_rx low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_r <= 1'b0;
      end else begin
         active_r <= 1'b1;
      end
   end

   // Occupancy update from the push/pop pair.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + ONE_C;
         2'b01:   count_next_s = count_r - ONE_C;
         default: count_next_s = count_r;
      endcase
   end

   // Pointer and occupancy registers; pointers carry an extra wrap bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= ZERO_C;
         rd_ptr_r <= ZERO_C;
         count_r  <= ZERO_C;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_C;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_C;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r <= count_next_s;
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {first_rx, last_rx, payload_rx};
      end
   end

   // Head presentation, zeroed whenever the FIFO is empty.
   always_comb begin
      if (valid_tx) begin
         first_tx   = head_s[WIDTH+1];
         last_tx    = head_s[WIDTH];
         payload_tx = head_s[WIDTH-1:0];
      end else begin
         first_tx   = 1'b0;
         last_tx    = 1'b0;
         payload_tx = {WIDTH{1'b0}};
      end
   end

`ifdef STREAM_FIFO_FRAME_CHECK_EN
   typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} frame_state_t;

   frame_state_t state_r;
   frame_state_t state_next_s;
   logic         err_set_s;
   logic         frame_err_r;

   // Framing tracker state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Framing tracker next state, advanced only by accepted beats.
   always_comb begin
      state_next_s = state_r;
      if (push_s) begin
         case (state_r)
            IDLE:    state_next_s = (first_rx & ~last_rx) ? IN_PKT : IDLE;
            IN_PKT:  state_next_s = last_rx ? IDLE : IN_PKT;
            default: state_next_s = IDLE;
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Framing violation detect: missing first in IDLE, repeated first in IN_PKT.
   always_comb begin
      err_set_s = 1'b0;
      if (push_s) begin
         case (state_r)
            IDLE:    err_set_s = ~first_rx;
            IN_PKT:  err_set_s = first_rx;
            default: err_set_s = 1'b0;
         endcase
      end else begin
         err_set_s = 1'b0;
      end
   end

   // Sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_err_r <= 1'b0;
      end else begin
         frame_err_r <= frame_err_r | err_set_s;
      end
   end

   assign frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: directed fill/drain/stream/reset tests plus a
// scoreboarded random-stall run; framing checks when STREAM_FIFO_FRAME_CHECK_EN is set.
module tb_stream_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int PW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_rx, ready_rx, first_rx, last_rx;
   logic [WIDTH-1:0] payload_rx;
   logic             valid_tx, ready_tx, first_tx, last_tx;
   logic [WIDTH-1:0] payload_tx;
   logic [PW-1:0]    count;
`ifdef STREAM_FIFO_FRAME_CHECK_EN
   logic             frame_err;
`endif

   int checks = 0;
   int errors = 0;
   int push_cnt = 0;
   logic [WIDTH+1:0] sb[$];
   logic             prev_stall = 1'b0;
   logic [WIDTH+2:0] prev_out;

   stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .valid_rx(valid_rx), .ready_rx(ready_rx), .first_rx(first_rx), .last_rx(last_rx),
      .payload_rx(payload_rx),
      .valid_tx(valid_tx), .ready_tx(ready_tx), .first_tx(first_tx), .last_tx(last_tx),
      .payload_tx(payload_tx),
`ifdef STREAM_FIFO_FRAME_CHECK_EN
      .frame_err(frame_err),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reset discards everything the FIFO held.
   always @(negedge rst) begin
      sb.delete();
      prev_stall = 1'b0;
   end

   // Monitor at negedge: outputs settled, inputs stable until after next posedge.
   always @(negedge clk) begin
      if (rst) begin
         check_val("count_vs_model", 64'(count), 64'(sb.size()));
         check_val("count_le_depth", 64'(count <= PW'(DEPTH)), 64'd1);
         if (!valid_tx)
            check_val("idle_outputs_zero", {30'd0, first_tx, last_tx, payload_tx}, 64'd0);
         if (prev_stall)
            check_val("stall_stable", 64'({valid_tx, first_tx, last_tx, payload_tx}), 64'(prev_out));
         prev_stall = valid_tx & ~ready_tx;
         prev_out   = {valid_tx, first_tx, last_tx, payload_tx};
         if (valid_tx && ready_tx) begin
            if (sb.size() == 0) begin
               check_val("pop_underflow", 64'd1, 64'd0);
            end else begin
               check_val("pop_beat", 64'({first_tx, last_tx, payload_tx}), 64'(sb.pop_front()));
            end
         end
         if (valid_rx && ready_rx) begin
            sb.push_back({first_rx, last_rx, payload_rx});
            push_cnt++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic f, input logic l, input logic [WIDTH-1:0] d);
      valid_rx = v; first_rx = f; last_rx = l; payload_rx = d;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      valid_rx = 1'b0;
      ready_tx = 1'b1;
      while ((valid_tx || sb.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check_val("drain_done", 64'(n < budget), 64'd1);
   endtask

   initial begin
      rst = 1'b0;
      ready_tx = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0);
      #2;
      check_val("rst_count", 64'(count), 64'd0);
      check_val("rst_valid_tx", 64'(valid_tx), 64'd0);
      check_val("rst_ready_rx", 64'(ready_rx), 64'd0);
      check_val("rst_payload", 64'(payload_tx), 64'd0);
      step(); step();
      rst = 1'b1;
      check_val("ready_before_edge", 64'(ready_rx), 64'd0);
      step();
      check_val("ready_after_edge", 64'(ready_rx), 64'd1);

      // Fill
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'hA0 + 32'(i));
         step();
         check_val("fill_count", 64'(count), 64'(i + 1));
      end
      check_val("full_ready_low", 64'(ready_rx), 64'd0);
      drive(1'b1, 1'b0, 1'b0, 32'hA4);
      step();
      check_val("full_hold_count", 64'(count), 64'd4);
      check_val("full_valid_tx", 64'(valid_tx), 64'd1);
      check_val("full_head", 64'(payload_tx), 64'hA0);

      // Drain
      ready_tx = 1'b1;
      step();
      check_val("drain_head1", 64'(payload_tx), 64'hA1);
      check_val("drain_ready_up", 64'(ready_rx), 64'd1);
      check_val("drain_count1", 64'(count), 64'd3);
      step();
      drive(1'b0, 1'b0, 1'b0, '0);
      check_val("drain_head2", 64'(payload_tx), 64'hA2);
      check_val("drain_count2", 64'(count), 64'd3);
      step();
      check_val("drain_head3", 64'(payload_tx), 64'hA3);
      step();
      check_val("drain_head4", 64'(payload_tx), 64'hA4);
      step();
      check_val("drain_empty_valid", 64'(valid_tx), 64'd0);
      check_val("drain_empty_count", 64'(count), 64'd0);

      // Streaming with pointer wrap
      ready_tx = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, i == 0, i == 9, 32'(i));
         step();
         check_val("stream_count", 64'(count), 64'd1);
         check_val("stream_head", 64'(payload_tx), 64'(i));
         check_val("stream_first", 64'(first_tx), 64'(i == 0));
         check_val("stream_last", 64'(last_tx), 64'(i == 9));
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      step();
      check_val("stream_end_empty", 64'(valid_tx), 64'd0);

      // Random stall
      begin
         int start, cyc;
         start = push_cnt;
         cyc = 0;
         while (push_cnt - start < 200 && cyc < 5000) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom);
            ready_tx = ($urandom_range(0, 2) != 0);
            step();
            cyc++;
         end
         check_val("random_budget", 64'(cyc < 5000), 64'd1);
      end
      drain(100);

      // Reset mid-operation
      ready_tx = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 32'hC0 + 32'(i));
         step();
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      check_val("pre_reset_count", 64'(count), 64'd3);
      #2;
      rst = 1'b0;
      #1;
      check_val("async_valid_tx", 64'(valid_tx), 64'd0);
      check_val("async_count", 64'(count), 64'd0);
      check_val("async_ready_rx", 64'(ready_rx), 64'd0);
      drive(1'b1, 1'b1, 1'b1, 32'hDEAD);
      step(); step();
      drive(1'b0, 1'b0, 1'b0, '0);
      rst = 1'b1;
      check_val("rel_ready_low", 64'(ready_rx), 64'd0);
      step();
      check_val("rel_ready_high", 64'(ready_rx), 64'd1);
      check_val("rel_no_stale", 64'(valid_tx), 64'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h55);
      step();
      drive(1'b0, 1'b0, 1'b0, '0);
      check_val("post_reset_beat", 64'(payload_tx), 64'h55);
      drain(20);

`ifdef STREAM_FIFO_FRAME_CHECK_EN
      do_reset();
      check_val("ferr_reset", 64'(frame_err), 64'd0);
      ready_tx = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'hF0);
      step();
      check_val("ferr_after_first", 64'(frame_err), 64'd0);
      drive(1'b1, 1'b1, 1'b1, 32'hF1);
      step();
      drive(1'b0, 1'b0, 1'b0, '0);
      check_val("ferr_set", 64'(frame_err), 64'd1);
      drain(20);
      repeat (3) step();
      check_val("ferr_sticky", 64'(frame_err), 64'd1);
      do_reset();
      check_val("ferr_cleared", 64'(frame_err), 64'd0);
`endif

      check_val("sb_empty_end", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
